// File: rtl/ode_sample_capture.sv
// ode_sample_capture: AXI4-Stream sink for the Lorenz solver's {x,y,z} stream.
// Stores accepted triples in a DEPTH-entry FIFO and drains them through a
// registered pop/read port. Backpressure via s_axis_ready when full.
// Optional feature macro: ODE_CAPTURE_DECIM_EN keeps 1 of (decim+1) beats;
// dropped beats are still handshaken so the solver never stalls on them.
module ode_sample_capture #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  s_axis_valid,
    output logic                  s_axis_ready,
    input  logic [DATA_WIDTH-1:0] s_axis_data_x,
    input  logic [DATA_WIDTH-1:0] s_axis_data_y,
    input  logic [DATA_WIDTH-1:0] s_axis_data_z,
    input  logic [7:0]            decim,
    input  logic                  rd_en,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data_x,
    output logic [DATA_WIDTH-1:0] rd_data_y,
    output logic [DATA_WIDTH-1:0] rd_data_z,
    output logic [ADDR_W:0]       level,
    output logic                  empty,
    output logic                  full
);

    localparam int                TRIPLE_W  = 3 * DATA_WIDTH;
    localparam logic [ADDR_W-1:0] PTR_ONE   = 1;
    localparam logic [ADDR_W:0]   LVL_ONE   = 1;
    localparam logic [ADDR_W:0]   LVL_FULL  = (ADDR_W+1)'(DEPTH);

    // Triple storage; never cleared, contents are meaningless once popped.
    logic [TRIPLE_W-1:0] r_mem [DEPTH];

    logic [ADDR_W-1:0]     r_wr_ptr;
    logic [ADDR_W-1:0]     r_rd_ptr;
    logic [ADDR_W:0]       r_level;
    logic                  r_empty;
    logic                  r_full;
    logic                  r_rd_valid;
    logic [DATA_WIDTH-1:0] r_rd_data_x;
    logic [DATA_WIDTH-1:0] r_rd_data_y;
    logic [DATA_WIDTH-1:0] r_rd_data_z;

    logic                  w_accept;
    logic                  w_keep;
    logic                  w_store;
    logic                  w_pop;
    logic [ADDR_W:0]       w_level_next;

`ifdef ODE_CAPTURE_DECIM_EN
    logic [7:0] r_dec_cnt;

    assign w_keep       = (r_dec_cnt == 8'd0);
    // A beat that will be dropped needs no FIFO slot, so accept it even when full.
    assign s_axis_ready = reset_n & (~r_full | ~w_keep);

    // Decimation phase counter: advances on every handshaken beat.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_dec_cnt <= 8'd0;
        end else if (w_accept) begin
            r_dec_cnt <= (r_dec_cnt >= decim) ? 8'd0 : r_dec_cnt + 8'd1;
        end
    end
`else
    logic w_unused_decim;

    assign w_unused_decim = ^decim;
    assign w_keep         = 1'b1;
    assign s_axis_ready   = reset_n & ~r_full;
`endif

    assign w_accept = s_axis_valid & s_axis_ready;
    assign w_store  = w_accept & w_keep;
    // empty is registered, so a beat written this cycle cannot be popped yet.
    assign w_pop    = rd_en & ~r_empty;

    // Occupancy after this edge: a simultaneous store and pop cancel out.
    always_comb begin
        w_level_next = r_level;
        case ({w_store, w_pop})
            2'b10:   w_level_next = r_level + LVL_ONE;
            2'b01:   w_level_next = r_level - LVL_ONE;
            default: w_level_next = r_level;
        endcase
    end

    // Storage write port; ready is low in reset so nothing is written then.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[r_wr_ptr] <= {s_axis_data_x, s_axis_data_y, s_axis_data_z};
        end
    end

    // Pointers, occupancy flags and the registered read port.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_empty     <= 1'b1;
            r_full      <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_data_x <= '0;
            r_rd_data_y <= '0;
            r_rd_data_z <= '0;
        end else begin
            r_rd_valid <= w_pop;
            if (w_store) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
                {r_rd_data_x, r_rd_data_y, r_rd_data_z} <= r_mem[r_rd_ptr];
            end
            r_level <= w_level_next;
            r_empty <= (w_level_next == '0);
            r_full  <= (w_level_next == LVL_FULL);
        end
    end

    assign rd_valid  = r_rd_valid;
    assign rd_data_x = r_rd_data_x;
    assign rd_data_y = r_rd_data_y;
    assign rd_data_z = r_rd_data_z;
    assign level     = r_level;
    assign empty     = r_empty;
    assign full      = r_full;

endmodule
